// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package inst_fetch_pkg;

    localparam int DEF_PC_W   = 4;
    localparam int DEF_INST_W = 1;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INST_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// rtl/fetch_fifo2.sv - two-entry synchronous FIFO with flush and full-with-pop push
module fetch_fifo2
    import inst_fetch_pkg::*;
#(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush drops contents but keeps stored words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC sequencer and fetch FSM feeding a 2-entry output FIFO; INST_FETCH_END_HALT_EN enables halt at end of ROM
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INST_W   = DEF_INST_W,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    output logic              halted
);

    state_t     state;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       push;
    logic       halt_active;
    logic       at_end;

    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign halt_active = (state == HALT);
    assign at_end      = (pc == {PC_W{1'b1}});
    // Redirect suppresses the push; otherwise fetch whenever a slot exists after this cycle's pop.
    assign push        = !redir_valid && run && !halt_active && (!fifo_full || pop);

`ifdef INST_FETCH_END_HALT_EN
    assign halted = halt_active;
`else
    assign halted = 1'b0;
`endif

    fetch_fifo2 #(
        .DW (PC_W + INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redir_valid),
        .push  (push),
        .din   ({pc, inst}),
        .pop   (pop),
        .dout  ({out_pc, out_inst}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PC register and fetch state; redirect outranks everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= START_PC;
            state <= FETCH;
        end else if (redir_valid) begin
            pc    <= redir_pc;
            state <= FETCH;
        end else if (push) begin
`ifdef INST_FETCH_END_HALT_EN
            if (at_end) begin
                state <= HALT;
            end else begin
                pc    <= pc + 1'b1;
                state <= FETCH;
            end
`else
            pc    <= pc + 1'b1;
            state <= at_end ? FETCH : FETCH;
`endif
        end else if (!halt_active) begin
            state <= STALL;
        end
    end

endmodule
